// File: rtl/apb_uart_pkg.sv
// ---------------------------------------------------------------------------
// apb_uart_pkg
// Shared definitions for the APB front-end of the UART core:
//   - register address map (8-bit byte addresses)
//   - bridge FSM state encoding
//   - request-kind encoding produced by the address decoder
//   - helper functions that map a request kind to read direction / strobes
// ---------------------------------------------------------------------------
package apb_uart_pkg;

    localparam logic [7:0] BAUD_ADDR    = 8'h00;
    localparam logic [7:0] FRAME_ADDR   = 8'h04;
    localparam logic [7:0] PARITY_ADDR  = 8'h08;
    localparam logic [7:0] SBITS_ADDR   = 8'h0C;
    localparam logic [7:0] TX_DATA_ADDR = 8'h10;
    localparam logic [7:0] RX_DATA_ADDR = 8'h14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        ERR   = 2'd3
    } bridge_state_t;

    typedef enum logic [2:0] {
        REQ_CFG_WR  = 3'd0,
        REQ_CFG_RD  = 3'd1,
        REQ_TX      = 3'd2,
        REQ_RX      = 3'd3,
        REQ_ILLEGAL = 3'd4
    } req_kind_t;

    // True for request kinds whose completion returns core read data.
    function automatic logic is_read_kind(input req_kind_t kind);
        return (kind == REQ_CFG_RD) || (kind == REQ_RX);
    endfunction

    // One-hot strobe vector {TX, RX, CFG_WR, CFG_RD} for a request kind.
    function automatic logic [3:0] kind_strobes(input req_kind_t kind);
        logic [3:0] strobes;
        case (kind)
            REQ_TX:     strobes = 4'b1000;
            REQ_RX:     strobes = 4'b0100;
            REQ_CFG_WR: strobes = 4'b0010;
            REQ_CFG_RD: strobes = 4'b0001;
            default:    strobes = 4'b0000;
        endcase
        return strobes;
    endfunction

endpackage

// File: rtl/apb_uart_addr_decode.sv
// ---------------------------------------------------------------------------
// apb_uart_addr_decode
// Purely combinational classification of an APB access.
//   paddr_i  : APB address
//   pwrite_i : 1 = write
//   kind_o   : request kind; REQ_ILLEGAL for unmapped addresses, writes to
//              RX_DATA and reads from TX_DATA
// ---------------------------------------------------------------------------
module apb_uart_addr_decode
    import apb_uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic                  pwrite_i,
    output req_kind_t             kind_o
);

    // Address/direction to request-kind lookup.
    always_comb begin
        kind_o = REQ_ILLEGAL;
        case (paddr_i)
            ADDR_WIDTH'(BAUD_ADDR),
            ADDR_WIDTH'(FRAME_ADDR),
            ADDR_WIDTH'(PARITY_ADDR),
            ADDR_WIDTH'(SBITS_ADDR): begin
                if (pwrite_i) begin
                    kind_o = REQ_CFG_WR;
                end else begin
                    kind_o = REQ_CFG_RD;
                end
            end
            ADDR_WIDTH'(TX_DATA_ADDR): begin
                if (pwrite_i) begin
                    kind_o = REQ_TX;
                end else begin
                    kind_o = REQ_ILLEGAL;
                end
            end
            ADDR_WIDTH'(RX_DATA_ADDR): begin
                if (pwrite_i) begin
                    kind_o = REQ_ILLEGAL;
                end else begin
                    kind_o = REQ_RX;
                end
            end
            default: kind_o = REQ_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/apb_uart_apb_bridge.sv
// ---------------------------------------------------------------------------
// apb_uart_apb_bridge
// APB3 slave that turns setup/access phases into level-held request strobes
// for the UART core and returns PRDATA/PREADY/PSLVERR once the core answers,
// a timeout fires, or the access is rejected locally.
//
// Ports
//   PCLK, PRESETn                 clock, synchronous active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request
//   PRDATA/PREADY/PSLVERR         APB response (registered)
//   write_data_out/config_address latched PWDATA/PADDR for the core
//   TX_detect/RX_detect/config_write_detect/config_read_detect
//                                 request strobes (one-hot, held until done)
//   read_data_in/uart_ready/uart_error  core response
// ---------------------------------------------------------------------------
module apb_uart_apb_bridge
    import apb_uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1048575
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [DATA_WIDTH-1:0] write_data_out,
    output logic [ADDR_WIDTH-1:0] config_address,
    output logic                  TX_detect,
    output logic                  RX_detect,
    output logic                  config_write_detect,
    output logic                  config_read_detect,
    input  logic [DATA_WIDTH-1:0] read_data_in,
    input  logic                  uart_ready,
    input  logic                  uart_error
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    bridge_state_t          state_q,   state_d;
    req_kind_t              kind_q,    kind_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0]  prdata_q,  prdata_d;
    logic                   pready_q,  pready_d;
    logic                   pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]  wdata_q,   wdata_d;
    logic [ADDR_WIDTH-1:0]  addr_q,    addr_d;
    logic [3:0]             strobe_q,  strobe_d;
    req_kind_t              dec_kind_s;

    apb_uart_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decode (
        .paddr_i  (PADDR),
        .pwrite_i (PWRITE),
        .kind_o   (dec_kind_s)
    );

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so that every port is driven straight from a flop.
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        strobe_d  = 4'b0000;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR;
                    wdata_d = PWDATA;
                    kind_d  = dec_kind_s;
                    cnt_d   = '0;
                    if (dec_kind_s == REQ_ILLEGAL) begin
                        state_d   = ERR;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else begin
                        state_d  = ISSUE;
                        strobe_d = kind_strobes(dec_kind_s);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (!PSEL) begin
                    // Master abandoned the transfer: drop the request silently.
                    state_d = IDLE;
                end else if ((cnt_q != '0) && uart_ready) begin
                    // cnt_q == 0 is the first request cycle; a ready seen
                    // there may be left over from the previous transfer.
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    pslverr_d = uart_error;
                    if (is_read_kind(kind_q)) begin
                        prdata_d = read_data_in;
                    end else begin
                        prdata_d = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    strobe_d = kind_strobes(kind_q);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            kind_q    <= REQ_ILLEGAL;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            wdata_q   <= '0;
            addr_q    <= '0;
            strobe_q  <= 4'b0000;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            strobe_q  <= strobe_d;
        end
    end

    assign PRDATA              = prdata_q;
    assign PREADY              = pready_q;
    assign PSLVERR             = pslverr_q;
    assign write_data_out      = wdata_q;
    assign config_address      = addr_q;
    assign TX_detect           = strobe_q[3];
    assign RX_detect           = strobe_q[2];
    assign config_write_detect = strobe_q[1];
    assign config_read_detect  = strobe_q[0];

endmodule

// File: tb/tb_apb_uart_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_uart_apb_bridge
// Directed bench for the APB-to-UART bridge. u_dut uses the default timeout;
// u_dut_to (TIMEOUT_CYCLES=16) has its own PSEL and is only selected for the
// timeout scenario. Inputs change 1 time unit after the rising edge and
// outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_apb_uart_apb_bridge;

    logic        PCLK;
    logic        presetn;
    logic        psel;
    logic        psel_to;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] rdata_in;
    logic        uready;
    logic        uerr;

    logic [31:0] prdata,   prdata_t;
    logic        pready,   pready_t;
    logic        pslverr,  pslverr_t;
    logic [31:0] wdo,      wdo_t;
    logic [7:0]  cfga,     cfga_t;
    logic        tx, rx, cw, cr;
    logic        tx_t, rx_t, cw_t, cr_t;

    int errors = 0;
    int checks = 0;
    int hi_cnt;

    apb_uart_apb_bridge u_dut (
        .PCLK                (PCLK),
        .PRESETn             (presetn),
        .PSEL                (psel),
        .PENABLE             (penable),
        .PWRITE              (pwrite),
        .PADDR               (paddr),
        .PWDATA              (pwdata),
        .PRDATA              (prdata),
        .PREADY              (pready),
        .PSLVERR             (pslverr),
        .write_data_out      (wdo),
        .config_address      (cfga),
        .TX_detect           (tx),
        .RX_detect           (rx),
        .config_write_detect (cw),
        .config_read_detect  (cr),
        .read_data_in        (rdata_in),
        .uart_ready          (uready),
        .uart_error          (uerr)
    );

    apb_uart_apb_bridge #(
        .TIMEOUT_CYCLES (16)
    ) u_dut_to (
        .PCLK                (PCLK),
        .PRESETn             (presetn),
        .PSEL                (psel_to),
        .PENABLE             (penable),
        .PWRITE              (pwrite),
        .PADDR               (paddr),
        .PWDATA              (pwdata),
        .PRDATA              (prdata_t),
        .PREADY              (pready_t),
        .PSLVERR             (pslverr_t),
        .write_data_out      (wdo_t),
        .config_address      (cfga_t),
        .TX_detect           (tx_t),
        .RX_detect           (rx_t),
        .config_write_detect (cw_t),
        .config_read_detect  (cr_t),
        .read_data_in        (rdata_in),
        .uart_ready          (uready),
        .uart_error          (uerr)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stb();
        return {28'd0, tx, rx, cw, cr};
    endfunction

    function automatic logic [31:0] stb_t();
        return {28'd0, tx_t, rx_t, cw_t, cr_t};
    endfunction

    task automatic setup(input logic wr, input logic [7:0] a, input logic [31:0] d);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
    endtask

    task automatic idle_bus();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    logic [7:0] ill_addr [3];
    logic       ill_wr   [3];

    initial begin
        presetn = 1'b0; psel = 1'b0; psel_to = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = 8'h00; pwdata = 32'd0;
        rdata_in = 32'd0; uready = 1'b0; uerr = 1'b0;
        ill_addr[0] = 8'h14; ill_wr[0] = 1'b1;
        ill_addr[1] = 8'h10; ill_wr[1] = 1'b0;
        ill_addr[2] = 8'h20; ill_wr[2] = 1'b0;

        // ---- reset state
        tick(); tick();
        chk("rst_pready",  {31'd0, pready},  32'd0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
        chk("rst_prdata",  prdata,           32'd0);
        chk("rst_strobes", stb(),            32'd0);
        chk("rst_wdo",     wdo,              32'd0);
        chk("rst_cfga",    {24'd0, cfga},    32'd0);
        presetn = 1'b1;
        tick();

        // ---- config write 0x00 = 115200, ready in the 3rd strobe cycle
        setup(1'b1, 8'h00, 32'd115200);
        tick(); penable = 1'b1;
        chk("cw_strobe0", stb(), 32'h2);
        chk("cw_addr",    {24'd0, cfga}, 32'h00);
        chk("cw_wdata",   wdo, 32'd115200);
        chk("cw_wait0",   {31'd0, pready}, 32'd0);
        tick();
        chk("cw_strobe1", stb(), 32'h2);
        tick();
        chk("cw_strobe2", stb(), 32'h2);
        chk("cw_wdata_hold", wdo, 32'd115200);
        uready = 1'b1;
        tick(); uready = 1'b0;
        chk("cw_resp_strobe",  stb(), 32'h0);
        chk("cw_resp_pready",  {31'd0, pready},  32'd1);
        chk("cw_resp_pslverr", {31'd0, pslverr}, 32'd0);
        idle_bus();
        tick();
        chk("cw_after_pready", {31'd0, pready}, 32'd0);

        // ---- RX read 0x14, core answers 0xA5 (ready early: first cycle blanked)
        setup(1'b0, 8'h14, 32'd0);
        tick(); penable = 1'b1;
        chk("rx_strobe0", stb(), 32'h4);
        rdata_in = 32'hA5; uready = 1'b1;
        tick();
        chk("rx_strobe_blank", stb(), 32'h4);
        chk("rx_wait", {31'd0, pready}, 32'd0);
        tick(); uready = 1'b0; rdata_in = 32'h5A;
        chk("rx_prdata", prdata, 32'hA5);
        chk("rx_pready", {31'd0, pready}, 32'd1);
        chk("rx_pslverr", {31'd0, pslverr}, 32'd0);
        chk("rx_strobe_off", stb(), 32'h0);
        idle_bus();
        tick();
        chk("rx_prdata_after", prdata, 32'h0);
        chk("rx_pready_after", {31'd0, pready}, 32'd0);

        // ---- TX write 0x10 = 0x55, ready after 1000 cycles with error
        setup(1'b1, 8'h10, 32'h55);
        tick(); penable = 1'b1;
        chk("tx_strobe0", stb(), 32'h8);
        chk("tx_wdata", wdo, 32'h55);
        hi_cnt = int'(tx);
        repeat (999) begin
            tick();
            hi_cnt += int'(tx);
        end
        uready = 1'b1; uerr = 1'b1;
        tick(); uready = 1'b0; uerr = 1'b0;
        chk("tx_high_cycles", hi_cnt, 32'd1000);
        chk("tx_pready",  {31'd0, pready},  32'd1);
        chk("tx_pslverr", {31'd0, pslverr}, 32'd1);
        chk("tx_prdata",  prdata, 32'd0);
        chk("tx_strobe_off", stb(), 32'h0);
        idle_bus();
        tick();

        // ---- illegal accesses: ERR in the access cycle, no strobe
        for (int i = 0; i < 3; i++) begin
            setup(ill_wr[i], ill_addr[i], 32'hDEAD);
            tick(); penable = 1'b1;
            chk("ill_pready",  {31'd0, pready},  32'd1);
            chk("ill_pslverr", {31'd0, pslverr}, 32'd1);
            chk("ill_prdata",  prdata, 32'd0);
            chk("ill_strobe",  stb(), 32'h0);
            tick();
            chk("ill_pready_off", {31'd0, pready}, 32'd0);
            chk("ill_strobe_off", stb(), 32'h0);
            idle_bus();
        end
        tick();

        // ---- timeout on the 16-cycle instance, read of 0x08 with junk data
        rdata_in = 32'hFFFF_FFFF;
        psel_to = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h08;
        tick(); penable = 1'b1;
        chk("to_strobe0", stb_t(), 32'h1);
        hi_cnt = int'(cr_t);
        repeat (15) begin
            tick();
            hi_cnt += int'(cr_t);
        end
        tick();
        chk("to_high_cycles", hi_cnt, 32'd16);
        chk("to_strobe_off", stb_t(), 32'h0);
        chk("to_pready",  {31'd0, pready_t},  32'd1);
        chk("to_pslverr", {31'd0, pslverr_t}, 32'd1);
        chk("to_prdata",  prdata_t, 32'd0);
        chk("to_main_idle", {31'd0, pready}, 32'd0);
        psel_to = 1'b0; penable = 1'b0; rdata_in = 32'd0;
        tick();
        chk("to_pready_off", {31'd0, pready_t}, 32'd0);

        // ---- reset during ISSUE
        setup(1'b1, 8'h0C, 32'd3);
        tick(); penable = 1'b1;
        chk("rst_mid_strobe", stb(), 32'h2);
        chk("rst_mid_cfga", {24'd0, cfga}, 32'h0C);
        presetn = 1'b0;
        tick();
        chk("rst_mid_strobe_off", stb(), 32'h0);
        chk("rst_mid_pready", {31'd0, pready}, 32'd0);
        chk("rst_mid_wdo", wdo, 32'd0);
        chk("rst_mid_cfga_off", {24'd0, cfga}, 32'd0);
        presetn = 1'b1; idle_bus();
        tick();

        // ---- PSEL dropped during ISSUE
        setup(1'b0, 8'h00, 32'd0);
        tick(); penable = 1'b1;
        chk("drop_strobe", stb(), 32'h1);
        idle_bus();
        tick();
        chk("drop_strobe_off", stb(), 32'h0);
        chk("drop_pready", {31'd0, pready}, 32'd0);
        tick();
        chk("drop_pready2", {31'd0, pready}, 32'd0);

        // ---- back-to-back with uart_ready stuck high
        uready = 1'b1; rdata_in = 32'h12;
        setup(1'b0, 8'h14, 32'd0);
        tick(); penable = 1'b1;
        chk("b2b_rx0", stb(), 32'h4);
        tick();
        chk("b2b_rx1", stb(), 32'h4);
        tick();
        chk("b2b_rx_pready", {31'd0, pready}, 32'd1);
        chk("b2b_rx_prdata", prdata, 32'h12);
        chk("b2b_rx_off", stb(), 32'h0);
        tick();
        chk("b2b_gap_strobe", stb(), 32'h0);
        chk("b2b_gap_pready", {31'd0, pready}, 32'd0);
        setup(1'b1, 8'h10, 32'h99);
        tick(); penable = 1'b1;
        chk("b2b_tx0", stb(), 32'h8);
        chk("b2b_tx_wdata", wdo, 32'h99);
        tick();
        chk("b2b_tx1", stb(), 32'h8);
        tick();
        chk("b2b_tx_pready", {31'd0, pready}, 32'd1);
        chk("b2b_tx_prdata", prdata, 32'd0);
        chk("b2b_tx_pslverr", {31'd0, pslverr}, 32'd0);
        uready = 1'b0; idle_bus();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
